eth_rx_frame_ctrl: RTL

Receive-side frame controller between the RMII PHY driver and the packet buffer. It takes the driver's dibit stream (`rx_dibit`/`rx_dibitclk`/`rx_done`), sequences an instance of `crc32`, and assembles bytes LSB-first into a single-frame buffer. At end of frame it checks the FCS, length and alignment, then commits the frame to the consumer with a valid/ready handshake or drops it and counts the drop.

---
 rtl/eth_pkg.sv | 21 ++
 rtl/crc32.sv | 32 +++
 rtl/eth_rx_frame_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive path: FSM states, CRC residue,
// frame length limits and address helpers.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } rx_state_t;

    localparam logic [31:0] CRC_RESIDUE    = 32'h1CDF4421;
    localparam int unsigned ETH_MIN_LEN    = 64;
    localparam int unsigned ETH_MAX_LEN    = 1518;
    localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    // Byte idx (0..5) of a MAC address in wire order, first byte = addr[47:40].
    function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
        return 8'(addr >> {3'd5 - idx, 3'b000});
    endfunction

endpackage

// File: rtl/crc32.sv
// Ethernet CRC-32 (reflected, init all-ones) advanced one dibit per inclk,
// LSB first. out is the complemented register in FCS wire byte order.
module crc32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inclk,
    input  logic [1:0]  din,
    output logic [31:0] out
);

    logic [31:0] lfsr;
    logic [31:0] lfsr_nxt;

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        return (c[0] ^ b) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    endfunction

    always_comb begin
        lfsr_nxt = crc_bit(crc_bit(lfsr, din[0]), din[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= '1;
        end else if (inclk) begin
            lfsr <= lfsr_nxt;
        end
    end

    assign out = ~{lfsr[7:0], lfsr[15:8], lfsr[23:16], lfsr[31:24]};

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Receive frame controller: dibit assembly into a single-frame buffer, FCS /
// length / alignment checks, commit handshake and drop counting.
// Optional destination filter: define ETH_RX_MAC_FILTER_EN.
module eth_rx_frame_ctrl
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MIN_LEN    = ETH_MIN_LEN,
    parameter int unsigned MAX_LEN    = ETH_MAX_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            rx_dibit,
    input  logic                  rx_dibitclk,
    input  logic                  rx_done,
    output logic                  buf_wr_en,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [7:0]            buf_wr_data,
    output logic                  frame_valid,
    output logic [ADDR_WIDTH-1:0] frame_len,
    input  logic                  frame_ready,
    output logic [7:0]            drop_cnt,
    output logic [7:0]            crc_err_cnt
);

    // One extra bit so an over-length frame is still distinguishable from MAX_LEN.
    localparam int unsigned   CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MIN_L = CW'(MIN_LEN);
    localparam logic [CW-1:0] MAX_L = CW'(MAX_LEN);

    if ((2 ** ADDR_WIDTH) < MAX_LEN) begin : g_bad_width
        $error("eth_rx_frame_ctrl: ADDR_WIDTH too small for MAX_LEN");
    end
    if (MAC_ADDR[40] || (MAC_ADDR == ETH_BCAST_ADDR)) begin : g_bad_mac
        $error("eth_rx_frame_ctrl: station address must be unicast");
    end

    rx_state_t state;
    rx_state_t state_nxt;

    logic [7:0]    shreg;
    logic [1:0]    phase;
    logic [CW-1:0] byte_cnt;
    logic          busy;

    logic          start;
    logic          busy_cur;
    logic [1:0]    phase_cur;
    logic [CW-1:0] cnt_cur;
    logic [7:0]    byte_new;
    logic          byte_done;
    logic          wr_ok;
    logic          rej_now;
    logic          filtered;
    logic          eval;
    logic          bad_crc;
    logic          drop;
    logic          commit;
    logic          crc_fault;
    logic          frame_take;

    logic          crc_rst;
    logic [31:0]   crc_out;

    // CRC also held in reset while HOLD is idle so a frame arriving behind a
    // pending one is checked from a clean seed.
    assign crc_rst = reset | (((state == ST_IDLE) || (state == ST_HOLD)) & ~rx_dibitclk);

    crc32 u_crc (
        .clk   (clk),
        .rst   (crc_rst),
        .inclk (rx_dibitclk),
        .din   (rx_dibit),
        .out   (crc_out)
    );

    // A dibit outside RECV is the first of a new frame: per-frame trackers restart.
    assign start      = rx_dibitclk & (state != ST_RECV);
    assign busy_cur   = start ? frame_valid : busy;
    assign phase_cur  = start ? 2'd0 : phase;
    assign cnt_cur    = start ? '0 : byte_cnt;
    assign byte_new   = {rx_dibit, shreg[7:2]};
    assign byte_done  = rx_dibitclk & (phase_cur == 2'd3);
    assign wr_ok      = byte_done & ~busy_cur & (cnt_cur < MAX_L) & ~rej_now;
    assign frame_take = frame_valid & frame_ready;

`ifdef ETH_RX_MAC_FILTER_EN
    logic uc_match;
    logic bc_match;
    logic uc_cur;
    logic bc_cur;
    logic uc_nxt;
    logic bc_nxt;
    logic filt_cur;

    always_comb begin
        uc_cur   = start ? 1'b1 : uc_match;
        bc_cur   = start ? 1'b1 : bc_match;
        filt_cur = start ? 1'b0 : filtered;
        uc_nxt   = uc_cur;
        bc_nxt   = bc_cur;
        rej_now  = filt_cur;
        if (byte_done && (cnt_cur < CW'(6))) begin
            uc_nxt  = uc_cur & (byte_new == addr_byte(MAC_ADDR, cnt_cur[2:0]));
            bc_nxt  = bc_cur & (byte_new == 8'hFF);
            rej_now = filt_cur | ~(uc_nxt | bc_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uc_match <= 1'b0;
            bc_match <= 1'b0;
            filtered <= 1'b0;
        end else if (rx_dibitclk) begin
            uc_match <= uc_nxt;
            bc_match <= bc_nxt;
            filtered <= rej_now;
        end
    end
`else
    assign rej_now  = 1'b0;
    assign filtered = 1'b0;
`endif

    assign eval    = (state == ST_RECV) & rx_done;
    assign bad_crc = (crc_out != CRC_RESIDUE);
    assign drop    = busy | (phase != 2'd0) | (byte_cnt < MIN_L) | (byte_cnt > MAX_L)
                   | bad_crc | filtered;
    assign commit  = eval & ~drop;
    // A misaligned frame never fed a whole FCS, so it is not an FCS error.
    assign crc_fault = eval & bad_crc & (phase == 2'd0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (rx_dibitclk) state_nxt = ST_RECV;
            ST_RECV: if (rx_done) state_nxt = drop ? ST_IDLE : ST_HOLD;
            ST_HOLD: begin
                if (rx_dibitclk)     state_nxt = ST_RECV;
                else if (frame_take) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg       <= '0;
            phase       <= '0;
            byte_cnt    <= '0;
            busy        <= 1'b0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            drop_cnt    <= '0;
            crc_err_cnt <= '0;
        end else begin
            buf_wr_en <= wr_ok;
            if (wr_ok) begin
                buf_wr_addr <= cnt_cur[ADDR_WIDTH-1:0];
                buf_wr_data <= byte_new;
            end

            if (rx_dibitclk) begin
                shreg    <= byte_new;
                phase    <= phase_cur + 2'd1;
                busy     <= busy_cur;
                byte_cnt <= (byte_done && (cnt_cur != '1)) ? cnt_cur + CW'(1) : cnt_cur;
            end

            if (commit) begin
                frame_valid <= 1'b1;
                frame_len   <= ADDR_WIDTH'(byte_cnt - CW'(4));
            end else if (frame_take) begin
                frame_valid <= 1'b0;
            end

            if (eval && drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (crc_fault && (crc_err_cnt != 8'hFF)) begin
                crc_err_cnt <= crc_err_cnt + 8'd1;
            end
        end
    end

endmodule
